mem_port_arbiter: RTL and testbench

// - Shares the single external memory port between instruction fetch (IC) and the ID-stage data access (DC).
// - Accepts one request at a time and sequences it through a req/ready + resp handshake. Returns read data to the owner.
// - Asserts a DC stall while a data access is in flight. Fixed DC priority, with an IC anti-starvation counter.

---
 rtl/mem_port_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory port between instruction fetch (IC)
// and the ID-stage data access (DC). One transaction in flight at a time, sequenced
// IDLE -> REQ -> WAIT -> RESP. DC has fixed priority. IC is forced through after
// STARVE_LIMIT consecutive DC grants while it is waiting.
// Optional feature macro: MEM_ARB_TIMEOUT_EN. When defined, a WAIT lasting
// TIMEOUT_CYCLES ends in an error response with zero data. When undefined, WAIT
// waits indefinitely and resp_err_o is tied low.
//
// Handshake semantics: a requester holds *_req_valid_i. The request is taken in the
// cycle where *_ready_o is high, and *_ready_o only rises in IDLE for the winner.
// mem_req_valid_o stays high with stable mem_* fields until the cycle where
// mem_req_ready_i is high. mem_resp_valid_i is only honoured in WAIT.
// *_resp_valid_o is a single-cycle pulse, and resp_err_o qualifies it.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ic_req_valid_i,
  input  logic [63:0] ic_addr_i,
  output logic        ic_ready_o,
  output logic        ic_resp_valid_o,
  output logic [63:0] ic_rdata_o,
  input  logic        dc_req_valid_i,
  input  logic        dc_wen_i,
  input  logic [63:0] dc_addr_i,
  input  logic [63:0] dc_wdata_i,
  input  logic [1:0]  dc_wlen_i,
  output logic        dc_ready_o,
  output logic        dc_resp_valid_o,
  output logic [63:0] dc_rdata_o,
  output logic        dc_stall_o,
  output logic        resp_err_o,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic        mem_wen_o,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  output logic [1:0]  mem_wlen_o,
  input  logic        mem_resp_valid_i,
  input  logic [63:0] mem_rdata_i,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [3:0] LP_STARVE = 4'(STARVE_LIMIT);

  state_t      r_state;
  logic        r_owner_dc;
  logic        r_wen;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [1:0]  r_wlen;
  logic [3:0]  r_starve_cnt;
  logic [63:0] r_ic_rdata;
  logic [63:0] r_dc_rdata;

  logic w_idle;
  logic w_ic_force;
  logic w_grant_ic;
  logic w_grant_dc;
  logic w_timeout;

  // Grant decision is only meaningful in IDLE. It is gated by reset so that no accept
  // is signalled while reset is being applied.
  assign w_idle     = rst && (r_state == S_IDLE);
  assign w_ic_force = ic_req_valid_i && (r_starve_cnt == LP_STARVE);
  assign w_grant_ic = w_idle && ic_req_valid_i && (!dc_req_valid_i || w_ic_force);
  assign w_grant_dc = w_idle && dc_req_valid_i && !w_grant_ic;

  assign ic_ready_o      = w_grant_ic;
  assign dc_ready_o      = w_grant_dc;
  assign ic_resp_valid_o = (r_state == S_RESP) && !r_owner_dc;
  assign dc_resp_valid_o = (r_state == S_RESP) && r_owner_dc;
  assign ic_rdata_o      = r_ic_rdata;
  assign dc_rdata_o      = r_dc_rdata;
  assign dc_stall_o      = w_grant_dc || (r_owner_dc && (r_state != S_IDLE));
  assign mem_req_valid_o = (r_state == S_REQ);
  assign mem_wen_o       = r_wen;
  assign mem_addr_o      = r_addr;
  assign mem_wdata_o     = r_wdata;
  assign mem_wlen_o      = r_wlen;
  assign dbg_state_o     = r_state;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [8:0] r_wait_cnt;
  logic       r_err;

  assign w_timeout  = (r_wait_cnt == 9'(TIMEOUT_CYCLES - 1));
  assign resp_err_o = (r_state == S_RESP) && r_err;

  // WAIT-state cycle counter. It is held at zero outside WAIT, so it starts fresh on each entry.
  always_ff @(posedge clk) begin
    if (!rst || (r_state != S_WAIT)) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= r_wait_cnt + 9'd1;
    end
  end

  // Error flag is set when WAIT ends by timeout, and is dropped once the RESP pulse is done.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (r_state == S_WAIT) begin
      r_err <= w_timeout && !mem_resp_valid_i;
    end else if (r_state == S_RESP) begin
      r_err <= 1'b0;
    end
  end
`else
  logic w_unused_cfg;

  assign w_timeout    = 1'b0;
  assign resp_err_o   = 1'b0;
  assign w_unused_cfg = (TIMEOUT_CYCLES == 0);
`endif

  // Transaction FSM: grant and latch in IDLE, present to memory, capture the response, pulse the owner.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_owner_dc   <= 1'b0;
      r_wen        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wlen       <= '0;
      r_starve_cnt <= '0;
      r_ic_rdata   <= '0;
      r_dc_rdata   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!ic_req_valid_i) begin
            r_starve_cnt <= '0;
          end
          if (w_grant_ic) begin
            r_owner_dc   <= 1'b0;
            r_wen        <= 1'b0;
            r_addr       <= ic_addr_i;
            r_wdata      <= '0;
            r_wlen       <= 2'd2;
            r_starve_cnt <= '0;
            r_state      <= S_REQ;
          end else if (w_grant_dc) begin
            r_owner_dc <= 1'b1;
            r_wen      <= dc_wen_i;
            r_addr     <= dc_addr_i;
            r_wdata    <= dc_wdata_i;
            r_wlen     <= dc_wlen_i;
            if (ic_req_valid_i && (r_starve_cnt < LP_STARVE)) begin
              r_starve_cnt <= r_starve_cnt + 4'd1;
            end
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_req_ready_i) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid_i) begin
            if (r_owner_dc) begin
              r_dc_rdata <= r_wen ? 64'd0 : mem_rdata_i;
            end else begin
              r_ic_rdata <= mem_rdata_i;
            end
            r_state <= S_RESP;
          end else if (w_timeout) begin
            if (r_owner_dc) begin
              r_dc_rdata <= 64'd0;
            end else begin
              r_ic_rdata <= 64'd0;
            end
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter. Expected responses are
// pushed as {is_dc, err, rdata}, and a negedge monitor pops them on every resp pulse.
module tb_mem_port_arbiter;

  localparam int W = 66;

  logic        clk;
  logic        rst;
  logic        ic_req_valid_i;
  logic [63:0] ic_addr_i;
  logic        ic_ready_o;
  logic        ic_resp_valid_o;
  logic [63:0] ic_rdata_o;
  logic        dc_req_valid_i;
  logic        dc_wen_i;
  logic [63:0] dc_addr_i;
  logic [63:0] dc_wdata_i;
  logic [1:0]  dc_wlen_i;
  logic        dc_ready_o;
  logic        dc_resp_valid_o;
  logic [63:0] dc_rdata_o;
  logic        dc_stall_o;
  logic        resp_err_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic        mem_wen_o;
  logic [63:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic [1:0]  mem_wlen_o;
  logic        mem_resp_valid_i;
  logic [63:0] mem_rdata_i;
  logic [1:0]  dbg_state_o;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(256)) dut (
    .clk(clk), .rst(rst),
    .ic_req_valid_i(ic_req_valid_i), .ic_addr_i(ic_addr_i), .ic_ready_o(ic_ready_o),
    .ic_resp_valid_o(ic_resp_valid_o), .ic_rdata_o(ic_rdata_o),
    .dc_req_valid_i(dc_req_valid_i), .dc_wen_i(dc_wen_i), .dc_addr_i(dc_addr_i),
    .dc_wdata_i(dc_wdata_i), .dc_wlen_i(dc_wlen_i), .dc_ready_o(dc_ready_o),
    .dc_resp_valid_o(dc_resp_valid_o), .dc_rdata_o(dc_rdata_o), .dc_stall_o(dc_stall_o),
    .resp_err_o(resp_err_o), .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_wlen_o(mem_wlen_o), .mem_resp_valid_i(mem_resp_valid_i), .mem_rdata_i(mem_rdata_i),
    .dbg_state_o(dbg_state_o)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every resp pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (ic_resp_valid_o || dc_resp_valid_o) begin
      if (ic_resp_valid_o && dc_resp_valid_o) begin
        n_checks++;
        n_fail++;
        $display("FAIL resp_both: got ic and dc pulses together, required one owner");
      end else if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL resp_unexpected: got pulse dc=%0b rdata=0x%0h, required none",
                 dc_resp_valid_o, dc_resp_valid_o ? dc_rdata_o : ic_rdata_o);
      end else begin
        check("resp", dc_resp_valid_o ? {1'b1, resp_err_o, dc_rdata_o} : {1'b0, resp_err_o, ic_rdata_o},
              exp_q.pop_front());
      end
    end
  end

  // Memory side of one transaction, entered in the first REQ cycle and left at the start of RESP
  task automatic do_mem(input int rdy_wait, input int rsp_wait, input logic [63:0] data,
                        input logic spurious, input logic e_wen, input logic [63:0] e_addr,
                        input logic [63:0] e_wdata, input logic [1:0] e_wlen);
    for (int i = 0; i <= rdy_wait; i++) begin
      mem_req_ready_i  = (i == rdy_wait);
      mem_resp_valid_i = spurious && (i < rdy_wait);
      mem_rdata_i      = 64'hDEAD_BEEF_DEAD_BEEF;
      @(negedge clk);
      check("mem_req_valid", W'(mem_req_valid_o), W'(1'b1));
      check("mem_fields", W'({mem_wen_o, mem_wlen_o, mem_addr_o ^ mem_wdata_o}),
            W'({e_wen, e_wlen, e_addr ^ e_wdata}));
      check("mem_wdata", W'(mem_wdata_o), W'(e_wdata));
      step();
    end
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b0;
    @(negedge clk);
    check("wait_no_req", W'(mem_req_valid_o), W'(1'b0));
    for (int i = 0; i < rsp_wait; i++) step();
    step();
    mem_resp_valid_i = 1'b1;
    mem_rdata_i      = data;
    step();
    mem_resp_valid_i = 1'b0;
    mem_rdata_i      = '0;
  endtask

  // Stimulus
  initial begin
    rst = 1'b0;
    ic_req_valid_i = 0; ic_addr_i = '0;
    dc_req_valid_i = 1; dc_wen_i = 0; dc_addr_i = 64'h1234; dc_wdata_i = '0; dc_wlen_i = 2'd3;
    mem_req_ready_i = 0; mem_resp_valid_i = 0; mem_rdata_i = '0;
    repeat (3) step();

    // Reset state: no accept while in reset, all outputs low
    @(negedge clk);
    check("rst_dc_ready", W'(dc_ready_o), W'(1'b0));
    check("rst_outputs", W'({ic_ready_o, ic_resp_valid_o, dc_resp_valid_o, dc_stall_o, resp_err_o,
                             mem_req_valid_o, mem_wen_o, mem_wlen_o, dbg_state_o}), W'(0));
    check("rst_data", W'(ic_rdata_o | dc_rdata_o | mem_addr_o | mem_wdata_o), W'(0));
    dc_req_valid_i = 0;
    step();
    rst = 1'b1;
    step();

    // Single DC load, minimum latency
    dc_req_valid_i = 1; dc_wen_i = 0; dc_addr_i = 64'h8000_1000; dc_wlen_i = 2'd3; dc_wdata_i = '0;
    @(negedge clk);
    check("load_ready", W'({dc_ready_o, ic_ready_o, dc_stall_o}), W'(3'b101));
    exp_q.push_back({1'b1, 1'b0, 64'h1122_3344_5566_7788});
    step();
    dc_req_valid_i = 0;
    do_mem(0, 0, 64'h1122_3344_5566_7788, 0, 1'b0, 64'h8000_1000, 64'd0, 2'd3);
    @(negedge clk);
    check("load_stall_resp", W'({dc_stall_o, dc_resp_valid_o}), W'(2'b11));
    step();
    @(negedge clk);
    check("load_stall_idle", W'({dc_stall_o, dc_resp_valid_o, dbg_state_o}), W'(0));

    // DC store: data returned by memory must be replaced by zero
    dc_req_valid_i = 1; dc_wen_i = 1; dc_addr_i = 64'h8000_2000; dc_wdata_i = 64'hAB; dc_wlen_i = 2'd0;
    exp_q.push_back({1'b1, 1'b0, 64'd0});
    step();
    dc_req_valid_i = 0; dc_wen_i = 0;
    do_mem(0, 1, 64'hFFFF_FFFF, 0, 1'b1, 64'h8000_2000, 64'hAB, 2'd0);
    step();

    // Simultaneous IC and DC: DC first, IC after the DC response, no accept in RESP
    ic_req_valid_i = 1; ic_addr_i = 64'h0000_4000;
    dc_req_valid_i = 1; dc_wen_i = 0; dc_addr_i = 64'h8000_3000; dc_wdata_i = '0; dc_wlen_i = 2'd2;
    @(negedge clk);
    check("both_ready", W'({dc_ready_o, ic_ready_o}), W'(2'b10));
    exp_q.push_back({1'b1, 1'b0, 64'hCAFE});
    step();
    dc_req_valid_i = 0;
    do_mem(0, 0, 64'hCAFE, 0, 1'b0, 64'h8000_3000, 64'd0, 2'd2);
    @(negedge clk);
    check("resp_no_accept", W'({ic_ready_o, dc_ready_o}), W'(0));
    step();
    @(negedge clk);
    check("ic_after_dc", W'({dc_ready_o, ic_ready_o, dc_stall_o}), W'(3'b010));
    exp_q.push_back({1'b0, 1'b0, 64'h0000_0000_0013_0001});
    step();
    ic_req_valid_i = 0;
    do_mem(0, 0, 64'h0000_0000_0013_0001, 0, 1'b0, 64'h0000_4000, 64'd0, 2'd2);
    @(negedge clk);
    check("ic_no_stall", W'(dc_stall_o), W'(1'b0));
    step();

    // Starvation: four DC grants, then IC forced, then DC again once the count clears
    ic_req_valid_i = 1; ic_addr_i = 64'h0000_5000;
    dc_req_valid_i = 1; dc_wen_i = 0; dc_addr_i = 64'h8000_6000; dc_wlen_i = 2'd3;
    for (int g = 0; g < 6; g++) begin
      @(negedge clk);
      check("starve_grant", W'({dc_ready_o, ic_ready_o}), (g == 4) ? W'(2'b01) : W'(2'b10));
      exp_q.push_back({(g != 4), 1'b0, 64'h100 + 64'(g)});
      step();
      do_mem(0, 0, 64'h100 + 64'(g), 0, 1'b0, (g == 4) ? 64'h0000_5000 : 64'h8000_6000,
             64'd0, (g == 4) ? 2'd2 : 2'd3);
      step();
    end
    ic_req_valid_i = 0; dc_req_valid_i = 0;
    step();

    // Memory not ready for 5 cycles with spurious responses in REQ, then a slow response
    dc_req_valid_i = 1; dc_wen_i = 1; dc_addr_i = 64'h8000_7008; dc_wdata_i = 64'h5A5A; dc_wlen_i = 2'd1;
    exp_q.push_back({1'b1, 1'b0, 64'd0});
    step();
    dc_req_valid_i = 0; dc_wen_i = 0;
    do_mem(5, 3, 64'h7777, 1, 1'b1, 64'h8000_7008, 64'h5A5A, 2'd1);
    step();

    // Reset during WAIT, then a late memory response must be dropped
    dc_req_valid_i = 1; dc_addr_i = 64'h8000_8000; dc_wlen_i = 2'd3; dc_wdata_i = '0;
    step();
    dc_req_valid_i = 0; mem_req_ready_i = 1;
    step();
    mem_req_ready_i = 0;
    @(negedge clk);
    check("in_wait", W'(dbg_state_o), W'(2'd2));
    rst = 1'b0;
    step();
    rst = 1'b1; mem_resp_valid_i = 1; mem_rdata_i = 64'h9999;
    @(negedge clk);
    check("rst_mid_idle", W'({dbg_state_o, dc_stall_o, mem_req_valid_o}), W'(0));
    step();
    mem_resp_valid_i = 0; mem_rdata_i = '0;
    @(negedge clk);
    check("rst_mid_drop", W'({dbg_state_o, dc_resp_valid_o}), W'(0));
    check("rst_mid_rdata", W'(dc_rdata_o), W'(0));
    repeat (3) step();

`ifdef MEM_ARB_TIMEOUT_EN
    // No response at all: error response with zero data after the timeout
    dc_req_valid_i = 1; dc_addr_i = 64'h8000_9000;
    exp_q.push_back({1'b1, 1'b1, 64'd0});
    step();
    dc_req_valid_i = 0; mem_req_ready_i = 1;
    step();
    mem_req_ready_i = 0;
    repeat (262) step();
`endif

    check("queue_empty", W'(exp_q.size()), W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
